prog_interval_timer: RTL and testbench

- Parametrised, programmable interval timer; next generation of the game's fixed free-running tick counter.
- Counts enabled clock cycles up to a run-time loadable terminal count (TC).
- Emits a one-cycle `timerout` pulse at each terminal count.
- Supports periodic and one-shot modes with explicit start/stop control; drives game pacing (sequence display, input timeouts).

---
 rtl/timer_pkg.sv | 13 +
 rtl/timer_prescaler.sv | 37 +++
 rtl/prog_interval_timer.sv | 102 ++++++++++
 tb/tb_prog_interval_timer.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared types for the programmable interval timer: FSM state and mode encodings.
package timer_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  localparam logic MODE_PERIODIC = 1'b0;
  localparam logic MODE_ONESHOT  = 1'b1;

endpackage

// File: rtl/timer_prescaler.sv
// Enabled-cycle divider: tick is high on every PRESCALE-th enabled cycle.
module timer_prescaler #(
  parameter int unsigned PRESCALE = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CntW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            at_last;

  assign at_last = (cnt_q == CntW'(PRESCALE - 1));
  assign tick    = en && at_last;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = at_last ? '0 : cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/prog_interval_timer.sv
// Programmable interval timer with periodic/one-shot modes and run-time loadable terminal count.
// Optional enabled-cycle prescaler is built when PRESCALE_EN is defined.
module prog_interval_timer
  import timer_pkg::*;
#(
  parameter int unsigned      WIDTH      = 25,
  parameter logic [WIDTH-1:0] DEFAULT_TC = {WIDTH{1'b1}},
  parameter int unsigned      PRESCALE   = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             start,
  input  logic             stop,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             mode,
  output logic             timerout,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] count
);

  if (WIDTH < 2 || PRESCALE < 1) begin : g_bad_params
    $error("prog_interval_timer: WIDTH must be >= 2 and PRESCALE >= 1");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] tc_q, tc_d;
  logic             timerout_q, timerout_d;
  logic             advance;

`ifdef PRESCALE_EN
  logic pre_clear;
  logic pre_tick;

  // Any control input realigns the prescaler so every interval starts from phase zero.
  assign pre_clear = stop | load | start;

  timer_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clk    (clk),
    .reset_n(reset_n),
    .en     (en && (state_q == StRun)),
    .clear  (pre_clear),
    .tick   (pre_tick)
  );

  assign advance = pre_tick;
`else
  assign advance = en;
`endif

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    tc_d       = tc_q;
    timerout_d = 1'b0;
    if (stop) begin
      state_d = StIdle;
      count_d = '0;
    end else if (load) begin
      tc_d    = load_value;
      count_d = '0;
    end else if (start) begin
      state_d = StRun;
      count_d = '0;
    end else if ((state_q == StRun) && advance) begin
      if (count_q == tc_q) begin
        timerout_d = 1'b1;
        count_d    = '0;
        if (mode == MODE_ONESHOT) begin
          state_d = StDone;
        end
      end else begin
        count_d = count_q + WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      count_q    <= '0;
      tc_q       <= DEFAULT_TC;
      timerout_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      tc_q       <= tc_d;
      timerout_q <= timerout_d;
    end
  end

  assign timerout = timerout_q;
  assign busy     = (state_q == StRun);
  assign done     = (state_q == StDone);
  assign count    = count_q;

endmodule

// File: tb/tb_prog_interval_timer.sv
// Directed self-checking bench for prog_interval_timer at WIDTH=4 (default build).
module tb_prog_interval_timer;

  localparam int unsigned WIDTH = 4;

  logic             clk;
  logic             reset_n;
  logic             en;
  logic             start;
  logic             stop;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic             mode;
  logic             timerout;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] count;

  int passed;
  int fails;
  int total;

  prog_interval_timer #(
    .WIDTH     (WIDTH),
    .DEFAULT_TC(4'd15),
    .PRESCALE  (4)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .en        (en),
    .start     (start),
    .stop      (stop),
    .load      (load),
    .load_value(load_value),
    .mode      (mode),
    .timerout  (timerout),
    .busy      (busy),
    .done      (done),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Steps n edges; timerout must be low for the first n-1 and high on the n-th.
  task automatic wait_pulse(input int n, input string tag);
    for (int i = 1; i <= n; i++) begin
      step();
      chk(tag, 32'(timerout), 32'(i == n));
    end
  endtask

  initial begin
    int pulses;
    passed     = 0;
    fails      = 0;
    total      = 0;
    reset_n    = 1'b0;
    en         = 1'b0;
    start      = 1'b0;
    stop       = 1'b0;
    load       = 1'b0;
    load_value = '0;
    mode       = 1'b0;

    // Reset state
    step();
    step();
    chk("rst_count", 32'(count), 0);
    chk("rst_timerout", 32'(timerout), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    #2 reset_n = 1'b1;
    step();
    chk("rst_release_timerout", 32'(timerout), 0);

    // Periodic at default tc=15: pulse 16 edges after start, then every 16
    en    = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("t1_busy", 32'(busy), 1);
    chk("t1_done", 32'(done), 0);
    chk("t1_count0", 32'(count), 0);
    wait_pulse(16, "t1_first_pulse");
    chk("t1_count_wrap", 32'(count), 0);
    wait_pulse(16, "t1_second_pulse");
    chk("t1_busy_after", 32'(busy), 1);

    // tc=3 periodic; a 2-cycle en drop stretches one interval to 6
    load       = 1'b1;
    load_value = 4'd3;
    step();
    load = 1'b0;
    chk("t2_load_busy", 32'(busy), 1);
    chk("t2_load_count", 32'(count), 0);
    start = 1'b1;
    step();
    start = 1'b0;
    wait_pulse(4, "t2_pulse_a");
    wait_pulse(4, "t2_pulse_b");
    step();
    chk("t2_count1", 32'(count), 1);
    en = 1'b0;
    step();
    step();
    chk("t2_hold_count", 32'(count), 1);
    chk("t2_hold_timerout", 32'(timerout), 0);
    en = 1'b1;
    wait_pulse(3, "t2_stretched");

    // One-shot with tc=5
    load       = 1'b1;
    load_value = 4'd5;
    mode       = 1'b1;
    step();
    load  = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    wait_pulse(6, "t3_oneshot_pulse");
    chk("t3_done", 32'(done), 1);
    chk("t3_busy", 32'(busy), 0);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (timerout) pulses++;
    end
    chk("t3_no_more_pulses", 32'(pulses), 0);
    chk("t3_count_idle", 32'(count), 0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("t3_restart_busy", 32'(busy), 1);
    wait_pulse(6, "t3_second_shot");
    chk("t3_done_again", 32'(done), 1);

    // tc=0 periodic: every enabled cycle pulses
    load       = 1'b1;
    load_value = 4'd0;
    mode       = 1'b0;
    step();
    load  = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    en    = 1'b1;
    step();
    chk("t4_en1_a", 32'(timerout), 1);
    step();
    chk("t4_en1_b", 32'(timerout), 1);
    en = 1'b0;
    step();
    chk("t4_en0", 32'(timerout), 0);
    en = 1'b1;
    step();
    chk("t4_en1_c", 32'(timerout), 1);
    // stop wins over simultaneous load and start, but load still takes effect? no: stop has priority
    stop       = 1'b1;
    load       = 1'b1;
    start      = 1'b1;
    load_value = 4'd9;
    step();
    stop  = 1'b0;
    load  = 1'b0;
    start = 1'b0;
    chk("t4_stop_busy", 32'(busy), 0);
    chk("t4_stop_done", 32'(done), 0);
    chk("t4_stop_timerout", 32'(timerout), 0);
    chk("t4_stop_count", 32'(count), 0);
    // tc stays 0 because stop blocks the load
    start = 1'b1;
    step();
    start = 1'b0;
    wait_pulse(1, "t4_tc_kept");

    // tc=9 then asynchronous reset at count=7
    load       = 1'b1;
    load_value = 4'd9;
    step();
    load = 1'b0;
    for (int i = 0; i < 7; i++) step();
    chk("t5_count7", 32'(count), 7);
    chk("t5_busy_pre", 32'(busy), 1);
    #2 reset_n = 1'b0;
    #1;
    chk("t5_async_count", 32'(count), 0);
    chk("t5_async_timerout", 32'(timerout), 0);
    chk("t5_async_busy", 32'(busy), 0);
    #1 reset_n = 1'b1;
    step();
    chk("t5_release_timerout", 32'(timerout), 0);
    chk("t5_release_busy", 32'(busy), 0);
    start = 1'b1;
    step();
    start = 1'b0;
    wait_pulse(16, "t5_tc_default");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
